// File: rtl/isr_stack.sv
// isr_stack: in-service register with a nesting stack of accepted channel IDs and a priority block mask
module isr_stack #(
    parameter int N_FAST = 3,
    parameter int N_NORM = 3,
    parameter int DEPTH  = 4,
    localparam int N     = N_FAST + N_NORM,
    localparam int ID_W  = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_i,
    input  logic [ID_W-1:0]  ld_id_i,
    input  logic             clr_i,
    input  logic             sclr_i,
    input  logic [ID_W-1:0]  sclr_id_i,
    input  logic             err_clr_i,
    output logic [N-1:0]     isr_o,
    output logic             cur_valid_o,
    output logic [ID_W-1:0]  cur_id_o,
    output logic [CNT_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [N-1:0]     block_mask_o,
    output logic [2:0]       err_o
);
    logic [ID_W-1:0]  stk_q [DEPTH];
    logic [ID_W-1:0]  stk_d [DEPTH];
    logic [ID_W-1:0]  stk_x [DEPTH+1];
    logic [N-1:0]     isr_q, isr_d, loh, soh;
    logic [CNT_W-1:0] lvl_q, lvl_d;
    logic [2:0]       err_q, err_d, ev;
    logic             hit, inv_ok;

    // One-hot of an ID; an ID >= N shifts out to zero, which doubles as the range check
    assign loh = N'(1) << ld_id_i;
    assign soh = N'(1) << sclr_id_i;

    // Retire (pop, or specific EOI with shift-down) first, then evaluate the push against the post-retire state
    always_comb begin
        stk_d = stk_q;
        isr_d = isr_q;
        lvl_d = lvl_q;
        ev    = '0;
        hit   = 1'b0;
        for (int k = 0; k < DEPTH; k++) stk_x[k] = stk_q[k];
        stk_x[DEPTH] = '0;
        if (clr_i) begin
            if (lvl_q == '0) ev[1] = 1'b1;
            else begin
                lvl_d = lvl_q - 1'b1;
                for (int k = 0; k < DEPTH; k++)
                    if (CNT_W'(k) == lvl_d) begin
                        isr_d    = isr_d & ~(N'(1) << stk_q[k]);
                        stk_d[k] = '0;
                    end
            end
        end else if (sclr_i) begin
            if (!(|(isr_q & soh))) ev[1] = 1'b1;
            else begin
                isr_d = isr_q & ~soh;
                lvl_d = lvl_q - 1'b1;
                for (int k = 0; k < DEPTH; k++) begin
                    hit = hit | ((stk_q[k] == sclr_id_i) && (CNT_W'(k) < lvl_q));
                    if (hit) stk_d[k] = stk_x[k+1];
                end
            end
        end
        if (ld_i) begin
            if (lvl_d == CNT_W'(DEPTH)) ev[0] = 1'b1;
            else if (!(|loh) || |(isr_d & loh)) ev[2] = 1'b1;
            else begin
                for (int k = 0; k < DEPTH; k++)
                    if (CNT_W'(k) == lvl_d) stk_d[k] = ld_id_i;
                isr_d = isr_d | loh;
                lvl_d = lvl_d + 1'b1;
            end
        end
        err_d = (err_clr_i ? 3'b000 : err_q) | ev;
    end

    // State registers; reset discards the whole stack at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stk_q <= '{default: '0};
            isr_q <= '0;
            lvl_q <= '0;
            err_q <= '0;
        end else begin
            stk_q <= stk_d;
            isr_q <= isr_d;
            lvl_q <= lvl_d;
            err_q <= err_d;
        end
    end

    assign isr_o       = isr_q;
    assign level_o     = lvl_q;
    assign err_o       = err_q;
    assign empty_o     = (lvl_q == '0);
    assign full_o      = (lvl_q == CNT_W'(DEPTH));
    assign cur_valid_o = !empty_o;

    // Top-of-stack select and mask of channels at or below current priority
    always_comb begin
        cur_id_o = '0;
        for (int k = 0; k < DEPTH; k++)
            if (CNT_W'(k) + 1'b1 == lvl_q) cur_id_o = stk_q[k];
        for (int i = 0; i < N; i++) block_mask_o[i] = cur_valid_o && (ID_W'(i) >= cur_id_o);
    end

    // Stack shape invariant: no duplicate live entries, zeros above the level
    always_comb begin
        inv_ok = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            if (CNT_W'(a) >= lvl_q && stk_q[a] != '0) inv_ok = 1'b0;
            for (int b = a + 1; b < DEPTH; b++)
                if (CNT_W'(b) < lvl_q && stk_q[a] == stk_q[b]) inv_ok = 1'b0;
        end
    end

    a_count: assert property (@(posedge clk_i) disable iff (!rst_ni) $countones(isr_q) == int'(lvl_q));
    a_shape: assert property (@(posedge clk_i) disable iff (!rst_ni) inv_ok);
endmodule
